// File: rtl/rw_manager_ac_pkg.sv
// Shared types and helpers for the writable RW manager AC instruction store.
package rw_manager_ac_pkg;

  typedef enum logic [0:0] {
    S_SCRUB = 1'b0,
    S_READY = 1'b1
  } ac_state_e;

  // AC word issued when the sequencer has nothing to drive.
  localparam logic [31:0] AC_NOP_WORD = 32'h0000_0000;

  localparam int PAR_MAX_W = 256;

  // Even parity; callers zero-extend to PAR_MAX_W, which leaves the result unchanged.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/rw_manager_ac_mem_array.sv
// Simple dual-port word array: one write port, one registered read port, old data on collision.
module rw_manager_ac_mem_array
  import rw_manager_ac_pkg::*;
#(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port, samples the array before this edge's write lands.
  always_ff @(posedge clock) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rw_manager_ac_ram.sv
// Writable AC instruction store: reset-time scrub, runtime patch port, 2-cycle reads, sticky parity.
module rw_manager_ac_ram
  import rw_manager_ac_pkg::*;
#(
  parameter int          DATA_WIDTH       = 32,
  parameter int          ADDR_WIDTH       = 6,
  parameter int          DEPTH            = 64,
  parameter int          RESTORE_ON_RESET = 1,
  parameter logic [31:0] DEFAULT_WORD     = AC_NOP_WORD,
  parameter int          PARITY_EN        = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wr_flip_par,
  output logic                  wr_err,
  output logic                  ready,
  output logic                  parity_err,
  input  logic                  err_clr
);

  localparam int                    PW          = (PARITY_EN != 0) ? 1 : 0;
  localparam int                    MW          = DATA_WIDTH + PW;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] DEFAULT_L   = DATA_WIDTH'(DEFAULT_WORD);
  localparam ac_state_e             RESET_STATE = (RESTORE_ON_RESET != 0) ? S_SCRUB : S_READY;

  ac_state_e             state_r;
  logic                  ready_r;
  logic [ADDR_WIDTH-1:0] scrub_addr_r;

  logic                  rd_req_r;
  logic                  rd_oor_r;
  logic [DATA_WIDTH-1:0] q_r;
  logic                  q_valid_r;
  logic                  wr_err_r;
  logic                  parity_err_r;

  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  wr_ok_s;
  logic                  rd_ok_s;
  logic                  scrub_active_s;
  logic                  mem_we_s;
  logic                  mem_re_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] wr_word_s;
  logic                  wr_par_s;
  logic [MW-1:0]         mem_wdata_s;
  logic [MW-1:0]         mem_rdata_s;
  logic                  rd_bad_s;

  // Range compares run on the full unsigned address so DEPTH < 2**ADDR_WIDTH works.
  assign wr_in_range_s  = ({1'b0, wraddress} < DEPTH_L);
  assign rd_in_range_s  = ({1'b0, rdaddress} < DEPTH_L);
  assign wr_ok_s        = wren & ready_r & wr_in_range_s & ~reset;
  assign rd_ok_s        = rden & ready_r & ~reset;
  assign mem_re_s       = rd_ok_s & rd_in_range_s;
  assign scrub_active_s = (state_r == S_SCRUB) & ~reset;

  // Write-port mux: the scrub owns the port until the array is ready.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = '0;
    wr_word_s   = '0;
    wr_par_s    = 1'b0;
    if (scrub_active_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = scrub_addr_r;
      wr_word_s   = DEFAULT_L;
      wr_par_s    = even_parity(PAR_MAX_W'(DEFAULT_L));
    end else if (wr_ok_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wraddress;
      wr_word_s   = data;
      wr_par_s    = even_parity(PAR_MAX_W'(data)) ^ wr_flip_par;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  generate
    if (PW == 1) begin : g_par
      assign mem_wdata_s = {wr_par_s, wr_word_s};
      assign rd_bad_s    = ^mem_rdata_s;
    end else begin : g_nopar
      assign mem_wdata_s = wr_word_s;
      assign rd_bad_s    = 1'b0;
    end
  endgenerate

  rw_manager_ac_mem_array #(
    .WIDTH      (MW),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (mem_wdata_s),
    .re    (mem_re_s),
    .raddr (rdaddress),
    .rdata (mem_rdata_s)
  );

  // Scrub/ready FSM: one default word per cycle, ready rises on the edge that writes the last word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= RESET_STATE;
      ready_r      <= 1'b0;
      scrub_addr_r <= '0;
    end else begin
      case (state_r)
        S_SCRUB: begin
          if (scrub_addr_r == LAST_ADDR) begin
            state_r      <= S_READY;
            ready_r      <= 1'b1;
            scrub_addr_r <= '0;
          end else begin
            scrub_addr_r <= scrub_addr_r + ADDR_WIDTH'(1);
          end
        end
        S_READY: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r      <= RESET_STATE;
          ready_r      <= 1'b0;
          scrub_addr_r <= '0;
        end
      endcase
    end
  end

  // Read pipeline output stage, write reject pulse and sticky parity flag (set beats clear).
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_req_r     <= 1'b0;
      rd_oor_r     <= 1'b0;
      q_r          <= '0;
      q_valid_r    <= 1'b0;
      wr_err_r     <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      rd_req_r  <= rd_ok_s;
      rd_oor_r  <= ~rd_in_range_s;
      q_valid_r <= rd_req_r;
      if (rd_req_r) begin
        q_r <= rd_oor_r ? '0 : mem_rdata_s[DATA_WIDTH-1:0];
      end
      wr_err_r <= wren & ~wr_ok_s;
      if (rd_req_r & ~rd_oor_r & rd_bad_s) begin
        parity_err_r <= 1'b1;
      end else if (err_clr) begin
        parity_err_r <= 1'b0;
      end
    end
  end

  assign q          = q_r;
  assign q_valid    = q_valid_r;
  assign wr_err     = wr_err_r;
  assign ready      = ready_r;
  assign parity_err = parity_err_r;

endmodule

// File: tb/tb_rw_manager_ac_ram.sv
// Self-checking bench for rw_manager_ac_ram: behavioural array model plus directed and random scenarios.
module tb_rw_manager_ac_ram;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, rden, wren, wr_flip_par, err_clr;
  logic [5:0]  rdaddress, wraddress;
  logic [31:0] data, q;
  logic        q_valid, wr_err, ready, parity_err;

  logic        b_reset, b_rden, b_wren, b_wr_flip_par, b_err_clr;
  logic [5:0]  b_rdaddress, b_wraddress;
  logic [31:0] b_data, b_q;
  logic        b_q_valid, b_wr_err, b_ready, b_parity_err;

  int n_run  = 0;
  int n_fail = 0;

  rw_manager_ac_ram #(.DEPTH(64), .RESTORE_ON_RESET(1)) dut (
    .clock(clock), .reset(reset), .rden(rden), .rdaddress(rdaddress), .q(q), .q_valid(q_valid),
    .wren(wren), .wraddress(wraddress), .data(data), .wr_flip_par(wr_flip_par), .wr_err(wr_err),
    .ready(ready), .parity_err(parity_err), .err_clr(err_clr)
  );

  rw_manager_ac_ram #(.DEPTH(40), .RESTORE_ON_RESET(0)) dut_b (
    .clock(clock), .reset(b_reset), .rden(b_rden), .rdaddress(b_rdaddress), .q(b_q), .q_valid(b_q_valid),
    .wren(b_wren), .wraddress(b_wraddress), .data(b_data), .wr_flip_par(b_wr_flip_par), .wr_err(b_wr_err),
    .ready(b_ready), .parity_err(b_parity_err), .err_clr(b_err_clr)
  );

  // Reference model of the 64-word instance: contents, corrupted-parity flags, one read in flight.
  logic [31:0] m_mem [64];
  bit          m_bad [64];
  int          m_scrub_left;
  bit          m_ready;
  bit          m_inf_req, m_inf_bad;
  logic [31:0] m_inf_data;
  logic [31:0] exp_q;
  bit          exp_qv, exp_wr_err, exp_ready, exp_perr;

  // Advance model and DUT by one clock edge using the currently driven inputs.
  task automatic tick();
    if (reset) begin
      exp_q = 32'h0; exp_qv = 1'b0; exp_wr_err = 1'b0; exp_perr = 1'b0;
      m_inf_req = 1'b0; m_scrub_left = 64; m_ready = 1'b0;
    end else begin
      exp_qv = m_inf_req;
      if (m_inf_req) exp_q = m_inf_data;
      if (m_inf_req && m_inf_bad) exp_perr = 1'b1;
      else if (err_clr) exp_perr = 1'b0;
      m_inf_req  = rden && m_ready;
      m_inf_data = m_mem[rdaddress];
      m_inf_bad  = m_bad[rdaddress];
      if (wren && m_ready) begin
        m_mem[wraddress] = data;
        m_bad[wraddress] = wr_flip_par;
        exp_wr_err = 1'b0;
      end else begin
        exp_wr_err = wren;
      end
      if (!m_ready) begin
        m_scrub_left--;
        if (m_scrub_left == 0) begin
          m_ready = 1'b1;
          for (int i = 0; i < 64; i++) begin
            m_mem[i] = 32'h0;
            m_bad[i] = 1'b0;
          end
        end
      end
    end
    exp_ready = m_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_run++; if (q !== exp_q) begin n_fail++; $display("FAIL reset_q: got %h want %h", q, exp_q); end
    n_run++; if (q_valid !== exp_qv) begin n_fail++; $display("FAIL reset_q_valid: got %b want %b", q_valid, exp_qv); end
    n_run++; if (ready !== exp_ready) begin n_fail++; $display("FAIL reset_ready: got %b want %b", ready, exp_ready); end
    n_run++; if (parity_err !== exp_perr) begin n_fail++; $display("FAIL reset_parity_err: got %b want %b", parity_err, exp_perr); end
    n_run++; if (wr_err !== exp_wr_err) begin n_fail++; $display("FAIL reset_wr_err: got %b want %b", wr_err, exp_wr_err); end
    reset = 1'b0;
    for (int c = 0; c < 64; c++) begin
      tick();
      n_run++; if (ready !== exp_ready) begin n_fail++; $display("FAIL scrub_ready cycle %0d: got %b want %b", c + 1, ready, exp_ready); end
    end
    for (int i = 0; i < 66; i++) begin
      rden = (i < 64); rdaddress = 6'(i);
      tick();
      n_run++; if (q_valid !== exp_qv) begin n_fail++; $display("FAIL scrub_read_valid %0d: got %b want %b", i, q_valid, exp_qv); end
      if (exp_qv) begin
        n_run++; if (q !== exp_q) begin n_fail++; $display("FAIL scrub_read_q %0d: got %h want %h", i, q, exp_q); end
      end
    end
    rden = 1'b0;
  endtask

  task automatic test_write_read();
    wren = 1'b1; wraddress = 6'h05; data = 32'h0C01_4208;
    tick();
    wren = 1'b0; rden = 1'b1; rdaddress = 6'h05;
    tick();
    rden = 1'b0;
    n_run++; if (q_valid !== exp_qv) begin n_fail++; $display("FAIL wr_rd_early_valid: got %b want %b", q_valid, exp_qv); end
    tick();
    n_run++; if (q_valid !== exp_qv) begin n_fail++; $display("FAIL wr_rd_valid: got %b want %b", q_valid, exp_qv); end
    n_run++; if (q !== exp_q) begin n_fail++; $display("FAIL wr_rd_q: got %h want %h", q, exp_q); end
    tick();
    n_run++; if (q_valid !== exp_qv) begin n_fail++; $display("FAIL wr_rd_valid_drop: got %b want %b", q_valid, exp_qv); end
  endtask

  task automatic test_collision();
    wren = 1'b1; wraddress = 6'h10; data = 32'h0C0D_0000;
    tick();
    data = 32'h1C0F_0000; rden = 1'b1; rdaddress = 6'h10;
    tick();
    wren = 1'b0; rden = 1'b0;
    tick();
    n_run++; if (q !== exp_q || q_valid !== 1'b1) begin n_fail++; $display("FAIL collision_old: got %h/%b want %h/1", q, q_valid, exp_q); end
    rden = 1'b1;
    tick();
    rden = 1'b0;
    tick();
    n_run++; if (q !== exp_q || q_valid !== 1'b1) begin n_fail++; $display("FAIL collision_new: got %h/%b want %h/1", q, q_valid, exp_q); end
  endtask

  task automatic test_parity();
    wren = 1'b1; wraddress = 6'h02; data = $urandom; wr_flip_par = 1'b1;
    tick();
    wren = 1'b0; wr_flip_par = 1'b0; rden = 1'b1; rdaddress = 6'h02;
    tick();
    rden = 1'b0;
    tick();
    n_run++; if (parity_err !== exp_perr) begin n_fail++; $display("FAIL parity_set: got %b want %b", parity_err, exp_perr); end
    for (int i = 0; i < 3; i++) tick();
    n_run++; if (parity_err !== exp_perr) begin n_fail++; $display("FAIL parity_sticky: got %b want %b", parity_err, exp_perr); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_run++; if (parity_err !== exp_perr) begin n_fail++; $display("FAIL parity_clear: got %b want %b", parity_err, exp_perr); end
    rden = 1'b1;
    tick();
    rden = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_run++; if (parity_err !== exp_perr) begin n_fail++; $display("FAIL parity_set_wins: got %b want %b", parity_err, exp_perr); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_run++; if (parity_err !== exp_perr) begin n_fail++; $display("FAIL parity_clear2: got %b want %b", parity_err, exp_perr); end
  endtask

  task automatic test_scrub_restart();
    int cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    wren = 1'b1; wraddress = 6'h07; data = $urandom;
    tick();
    wren = 1'b0;
    n_run++; if (wr_err !== exp_wr_err) begin n_fail++; $display("FAIL scrub_wr_err: got %b want %b", wr_err, exp_wr_err); end
    tick();
    n_run++; if (wr_err !== exp_wr_err) begin n_fail++; $display("FAIL scrub_wr_err_pulse: got %b want %b", wr_err, exp_wr_err); end
    n_run++; if (ready !== exp_ready) begin n_fail++; $display("FAIL scrub_mid_ready: got %b want %b", ready, exp_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    n_run++; if (cnt != 64) begin n_fail++; $display("FAIL scrub_restart_len: got %0d cycles want 64", cnt); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      rden = 1'($urandom); rdaddress = 6'($urandom_range(0, 7));
      wren = 1'($urandom); wraddress = 6'($urandom_range(0, 7)); data = $urandom;
      wr_flip_par = ($urandom_range(0, 15) == 0);
      err_clr = ($urandom_range(0, 7) == 0);
      tick();
      n_run++; if (q_valid !== exp_qv) begin n_fail++; $display("FAIL rand_valid c%0d: got %b want %b", c, q_valid, exp_qv); end
      if (exp_qv) begin
        n_run++; if (q !== exp_q) begin n_fail++; $display("FAIL rand_q c%0d: got %h want %h", c, q, exp_q); end
      end
      n_run++; if (wr_err !== exp_wr_err) begin n_fail++; $display("FAIL rand_wr_err c%0d: got %b want %b", c, wr_err, exp_wr_err); end
      n_run++; if (parity_err !== exp_perr) begin n_fail++; $display("FAIL rand_parity c%0d: got %b want %b", c, parity_err, exp_perr); end
    end
    rden = 1'b0; wren = 1'b0; wr_flip_par = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    d = $urandom;
    b_reset = 1'b1;
    @(posedge clock); #1;
    b_reset = 1'b0;
    @(posedge clock); #1;
    n_run++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready_no_scrub: got %b want 1", b_ready); end
    b_wren = 1'b1; b_wraddress = 6'd39; b_data = d;
    @(posedge clock); #1;
    n_run++; if (b_wr_err !== 1'b0) begin n_fail++; $display("FAIL oor_last_accepted: got %b want 0", b_wr_err); end
    b_wraddress = 6'd40;
    @(posedge clock); #1;
    b_wren = 1'b0;
    n_run++; if (b_wr_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err_40: got %b want 1", b_wr_err); end
    @(posedge clock); #1;
    n_run++; if (b_wr_err !== 1'b0) begin n_fail++; $display("FAIL oor_wr_err_pulse: got %b want 0", b_wr_err); end
    b_wren = 1'b1; b_wraddress = 6'h3F;
    @(posedge clock); #1;
    b_wren = 1'b0;
    n_run++; if (b_wr_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err_3f: got %b want 1", b_wr_err); end
    b_rden = 1'b1; b_rdaddress = 6'd39;
    @(posedge clock); #1;
    b_rden = 1'b0;
    @(posedge clock); #1;
    n_run++; if (b_q !== d || b_q_valid !== 1'b1) begin n_fail++; $display("FAIL oor_read_39: got %h/%b want %h/1", b_q, b_q_valid, d); end
    b_rden = 1'b1; b_rdaddress = 6'h3F;
    @(posedge clock); #1;
    b_rden = 1'b0;
    @(posedge clock); #1;
    n_run++; if (b_q !== 32'h0 || b_q_valid !== 1'b1) begin n_fail++; $display("FAIL oor_read_3f: got %h/%b want 0/1", b_q, b_q_valid); end
    n_run++; if (b_parity_err !== 1'b0) begin n_fail++; $display("FAIL oor_no_parity: got %b want 0", b_parity_err); end
  endtask

  initial begin
    reset = 1'b1; rden = 1'b0; wren = 1'b0; wr_flip_par = 1'b0; err_clr = 1'b0;
    rdaddress = 6'h0; wraddress = 6'h0; data = 32'h0;
    b_reset = 1'b1; b_rden = 1'b0; b_wren = 1'b0; b_wr_flip_par = 1'b0; b_err_clr = 1'b0;
    b_rdaddress = 6'h0; b_wraddress = 6'h0; b_data = 32'h0;
    m_scrub_left = 64; m_ready = 1'b0; m_inf_req = 1'b0;
    for (int i = 0; i < 64; i++) begin m_mem[i] = 32'h0; m_bad[i] = 1'b0; end
    test_reset();
    test_write_read();
    test_collision();
    test_parity();
    test_scrub_restart();
    test_back_to_back();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
